// File: rtl/rev_alu_serial_if.sv
// -----------------------------------------------------------------------------
// rev_alu_serial_if
//   Bundle for the digit-serial reversible ALU. It carries the operand-side and
//   result-side valid/ready handshakes.
//
//   Request side  : in_valid, in_ready, a, b, op
//   Response side : out_valid, out_ready, y, cout, ovf, zero
//
//   Modports:
//     master - the producer/consumer around the ALU. It drives the request and
//              out_ready.
//     slave  - the ALU itself. It drives in_ready and the result/flags.
// -----------------------------------------------------------------------------
interface rev_alu_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, cout, ovf, zero
  );
endinterface

// File: rtl/rev_alu_serial.sv
// -----------------------------------------------------------------------------
// rev_alu_serial
//   Digit-serial N-bit ALU. Each bit-slice is built from reversible gate cells:
//   Feynman (XOR/copy), Toffoli (AND), Peres pair (full add) and Fredkin
//   (operand/result steering). One operand pair is accepted per transaction.
//   DIGIT bits are processed per clock, LSB digit first. The result and flags
//   are returned over a second handshake.
//
//   Parameters:
//     WIDTH - operand/result width, multiple of DIGIT, >= 2
//     DIGIT - bits processed per clock, 1..WIDTH
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - rev_alu_serial_if.slave (in_valid/in_ready/a/b/op,
//            out_valid/out_ready/y/cout/ovf/zero)
//
//   Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR,
//             110 PASS A, 111 NOT A
//
//   Timing: acceptance at cycle 0, WIDTH/DIGIT BUSY cycles, then DONE holds
//   out_valid until out_ready. Latency to out_valid is WIDTH/DIGIT+1 clocks.
// -----------------------------------------------------------------------------
module rev_alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  rev_alu_serial_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Parameter legality: rejected while the design is being elaborated.
  // ---------------------------------------------------------------------------
  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("rev_alu_serial: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Reversible gate cells. Only the lines that carry information onward are
  // returned. The pass-through control lines equal the gate inputs, so the
  // caller already holds them.
  // ---------------------------------------------------------------------------

  // Feynman (CNOT): target' = a ^ b
  function automatic logic feynman(input logic ctl, input logic tgt);
    return ctl ^ tgt;
  endfunction

  // Toffoli (CCNOT): target' = (a & b) ^ c
  function automatic logic toffoli(input logic c1, input logic c2, input logic tgt);
    return (c1 & c2) ^ tgt;
  endfunction

  // Peres: {Q, R} = {a ^ b, (a & b) ^ c}
  function automatic logic [1:0] peres(input logic pa, input logic pb, input logic pc);
    return {pa ^ pb, (pa & pb) ^ pc};
  endfunction

  // Fredkin (controlled swap), first swapped output: ctl ? y : x
  function automatic logic fredkin(input logic ctl, input logic x, input logic y);
    return ctl ? y : x;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;     // digits assembled so far
  logic [WIDTH-1:0] y_q, y_d;         // presented result, updated only on BUSY->DONE
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Current operand digits, selected by the digit counter. The operand
  // registers themselves never shift.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;

  assign a_dig = a_q[cnt_q * DIGIT +: DIGIT];
  assign b_dig = b_q[cnt_q * DIGIT +: DIGIT];

  logic is_sub;
  logic is_arith;

  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = (op_q[2:1] == 2'b00);

  // ---------------------------------------------------------------------------
  // Bit-parallel part of the slices: operand steering, logic functions and the
  // first Peres gate of each full adder (half-sum and generate).
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] b_eff;   // b, inverted for SUB
  logic [DIGIT-1:0] half_v;  // a ^ b_eff
  logic [DIGIT-1:0] gen_v;   // a & b_eff
  logic [DIGIT-1:0] and_v;
  logic [DIGIT-1:0] xor_v;
  logic [DIGIT-1:0] or_v;
  logic [DIGIT-1:0] xnor_v;
  logic [DIGIT-1:0] nota_v;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_slice_pre
      // For the logic ops is_sub is 0, so b_eff is plain b there.
      assign b_eff[gi] = feynman(is_sub, b_dig[gi]);
      assign {half_v[gi], gen_v[gi]} = peres(a_dig[gi], b_eff[gi], 1'b0);
      assign and_v[gi]  = toffoli(a_dig[gi], b_eff[gi], 1'b0);
      assign xor_v[gi]  = feynman(a_dig[gi], b_eff[gi]);
      // OR built reversibly as (A^B)^(A&B)
      assign or_v[gi]   = feynman(xor_v[gi], and_v[gi]);
      assign xnor_v[gi] = feynman(1'b1, xor_v[gi]);
      assign nota_v[gi] = feynman(1'b1, a_dig[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Carry ripple through the digit. The second Peres gate of each slice turns
  // (half-sum, carry-in, generate) into (sum, carry-out). This is written as a
  // loop so the ripple stays inside one process.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] sum_v;
  logic             c_out;     // carry out of the digit's top bit
  logic             c_msb_in;  // carry into the digit's top bit

  always_comb begin
    logic       c;
    logic [1:0] pr;
    c        = carry_q;
    pr       = '0;
    sum_v    = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb_in = c;
      end
      pr       = peres(half_v[i], c, gen_v[i]);
      sum_v[i] = pr[1];
      c        = pr[0];
    end
    c_out = c;
  end

  // ---------------------------------------------------------------------------
  // Result steering: a three-level Fredkin tree on op bits 0, 1, 2.
  //   op[2:1] = 00 -> sum (ADD/SUB), 01 -> AND/OR, 10 -> XOR/XNOR,
  //   11 -> A/~A
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] dig_res;

  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_slice_sel
      logic m0, m1, m2, m3, n0, n1;
      assign m0 = fredkin(op_q[0], sum_v[gi], sum_v[gi]);
      assign m1 = fredkin(op_q[0], and_v[gi], or_v[gi]);
      assign m2 = fredkin(op_q[0], xor_v[gi], xnor_v[gi]);
      assign m3 = fredkin(op_q[0], a_dig[gi], nota_v[gi]);
      assign n0 = fredkin(op_q[1], m0, m1);
      assign n1 = fredkin(op_q[1], m2, m3);
      assign dig_res[gi] = fredkin(op_q[2], n0, n1);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath next-state
  // ---------------------------------------------------------------------------
  logic accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          // Two's-complement subtract injects the +1 as the initial carry.
          carry_d = (bus.op == OP_SUB);
          state_d = BUSY;
        end
      end

      BUSY: begin
        res_d[cnt_q * DIGIT +: DIGIT] = dig_res;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          // The last digit carries the MSB. It publishes the whole word and
          // its flags.
          cnt_d   = '0;
          state_d = DONE;
          y_d     = res_d;
          zero_d  = (res_d == '0);
          cout_d  = is_arith & c_out;
          ovf_d   = is_arith & (c_msb_in ^ c_out);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. in_ready is masked by rst so it reads low for the whole reset
  // pulse and rises as soon as reset is released.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_rev_alu_serial.sv
// -----------------------------------------------------------------------------
// tb_rev_alu_serial
//   Bench for rev_alu_serial. Three instances are used:
//     unit 0: WIDTH=16, DIGIT=4
//     unit 1: WIDTH=16, DIGIT=1
//     unit 2: WIDTH=16, DIGIT=16
//   Expected results come from an arithmetic reference model. They are queued
//   when a transaction is driven and popped when out_valid appears.
// -----------------------------------------------------------------------------
module tb_rev_alu_serial;

  localparam int W  = 16;
  localparam int NI = 3;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic         in_valid_v  [NI];
  logic [W-1:0] a_v         [NI];
  logic [W-1:0] b_v         [NI];
  logic [2:0]   op_v        [NI];
  logic         out_ready_v [NI];
  logic         in_ready_v  [NI];
  logic         out_valid_v [NI];
  res_t         res_v       [NI];

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DG = (gi == 0) ? 4 : (gi == 1) ? 1 : 16;
      rev_alu_serial_if #(.WIDTH(W)) bus ();
      assign bus.in_valid    = in_valid_v[gi];
      assign bus.a           = a_v[gi];
      assign bus.b           = b_v[gi];
      assign bus.op          = op_v[gi];
      assign bus.out_ready   = out_ready_v[gi];
      assign in_ready_v[gi]  = bus.in_ready;
      assign out_valid_v[gi] = bus.out_valid;
      assign res_v[gi]       = {bus.y, bus.cout, bus.ovf, bus.zero};
      rev_alu_serial #(.WIDTH(W), .DIGIT(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  // Reference model: plain integer arithmetic and bitwise operators.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    res_t       r;
    logic [W:0] s;
    r = '0;
    s = '0;
    case (op)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        r.y    = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.y[W-1] != a[W-1]);
      end
      3'd1: begin
        r.y    = a - b;
        r.cout = (a >= b);
        r.ovf  = (a[W-1] != b[W-1]) && (r.y[W-1] != a[W-1]);
      end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~(a ^ b);
      3'd6: r.y = a;
      default: r.y = ~a;
    endcase
    r.zero = (r.y == '0);
    return r;
  endfunction

  function automatic int lat_for(input int sel);
    return (sel == 0) ? 5 : (sel == 1) ? 17 : 2;
  endfunction

  // Drives one transaction on unit sel. It returns the observed result and the
  // number of clocks from the acceptance edge (counted as 1) to out_valid.
  // The task is entered and left at posedge+1.
  task automatic run_txn(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, output res_t obs, output int lat);
    int guard;
    exp_q.push_back(model(a, b, op));
    in_valid_v[sel] = 1'b1;
    a_v[sel]        = a;
    b_v[sel]        = b;
    op_v[sel]       = op;
    guard = 0;
    while (in_ready_v[sel] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    lat = 1;
    in_valid_v[sel] = 1'b0;
    a_v[sel]  = W'($urandom);
    b_v[sel]  = W'($urandom);
    op_v[sel] = 3'($urandom);
    while (out_valid_v[sel] !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (guard >= 50) lat = 999;
    obs = res_v[sel];
    $display("txn u%0d op=%0d a=%h b=%h -> y=%h c=%b v=%b z=%b lat=%0d",
             sel, op, a, b, obs.y, obs.cout, obs.ovf, obs.zero, lat);
  endtask

  task automatic release_out(input int sel);
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int s = 0; s < NI; s++) begin
      n_checks++;
      if (in_ready_v[s] !== 1'b0 || out_valid_v[s] !== 1'b0 || res_v[s] !== '0) begin
        n_fail++;
        $display("FAIL reset_hold u%0d: in_ready=%b out_valid=%b res=%h, required 0/0/0",
                 s, in_ready_v[s], out_valid_v[s], res_v[s]);
      end
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int s = 0; s < NI; s++) begin
      n_checks++;
      if (in_ready_v[s] !== 1'b1 || out_valid_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release u%0d: in_ready=%b out_valid=%b, required 1/0",
                 s, in_ready_v[s], out_valid_v[s]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    res_t obs, exp, cst;
    int   lat;
    run_txn(0, 16'h7FFF, 16'h0001, 3'b000, obs, lat);
    exp = exp_q.pop_front();
    cst = {16'h8000, 1'b0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL add_model: got %h, required %h", obs, exp);
    end
    n_checks++;
    if (obs !== cst) begin
      n_fail++;
      $display("FAIL add_const: got %h, required %h", obs, cst);
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL add_latency: got %0d, required 5", lat);
    end
    release_out(0);
    n_checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL add_release: in_ready=%b out_valid=%b, required 1/0", in_ready_v[0], out_valid_v[0]);
    end
  endtask

  task automatic test_sub();
    res_t obs, exp, cst;
    int   lat;
    run_txn(0, 16'h1234, 16'h1234, 3'b001, obs, lat);
    exp = exp_q.pop_front();
    cst = {16'h0000, 1'b1, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp || obs !== cst) begin
      n_fail++;
      $display("FAIL sub_equal: got %h, required %h", obs, cst);
    end
    release_out(0);
    run_txn(0, 16'h0000, 16'h0001, 3'b001, obs, lat);
    exp = exp_q.pop_front();
    cst = {16'hFFFF, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp || obs !== cst) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h, required %h", obs, cst);
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL sub_latency: got %0d, required 5", lat);
    end
    release_out(0);
  endtask

  task automatic test_logic();
    logic [W-1:0] tbl [6];
    res_t obs, exp;
    int   lat;
    tbl[0] = 16'hF000;  // AND
    tbl[1] = 16'hFFF0;  // OR
    tbl[2] = 16'h0FF0;  // XOR
    tbl[3] = 16'hF00F;  // XNOR
    tbl[4] = 16'hF0F0;  // PASS
    tbl[5] = 16'h0F0F;  // NOT
    for (int i = 0; i < 6; i++) begin
      run_txn(0, 16'hF0F0, 16'hFF00, 3'(i + 2), obs, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL logic_model op%0d: got %h, required %h", i + 2, obs, exp);
      end
      n_checks++;
      if (obs.y !== tbl[i] || obs.cout !== 1'b0 || obs.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL logic_table op%0d: got y=%h c=%b v=%b, required y=%h c=0 v=0",
                 i + 2, obs.y, obs.cout, obs.ovf, tbl[i]);
      end
      release_out(0);
    end
  endtask

  task automatic test_back_to_back();
    res_t obs, exp;
    int   lat;
    run_txn(0, 16'h1111, 16'h2222, 3'b000, obs, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp || lat != 5) begin
      n_fail++;
      $display("FAIL bp_first: got %h lat %0d, required %h lat 5", obs, lat, exp);
    end
    // The next pair is offered immediately and held while the result stalls.
    in_valid_v[0] = 1'b1;
    a_v[0]        = 16'hABCD;
    b_v[0]        = 16'h1357;
    op_v[0]       = 3'b100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (res_v[0] !== exp || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: res=%h out_valid=%b in_ready=%b, required %h/1/0",
                 i, res_v[0], out_valid_v[0], in_ready_v[0], exp);
      end
    end
    release_out(0);
    n_checks++;
    if (in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_turnaround: in_ready=%b, required 1", in_ready_v[0]);
    end
    run_txn(0, 16'hABCD, 16'h1357, 3'b100, obs, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp || lat != 5) begin
      n_fail++;
      $display("FAIL bp_second: got %h lat %0d, required %h lat 5", obs, lat, exp);
    end
    release_out(0);
  endtask

  task automatic test_reset_abort();
    int seen;
    in_valid_v[0] = 1'b1;
    a_v[0]        = 16'hFFFF;
    b_v[0]        = 16'h0001;
    op_v[0]       = 3'b000;
    @(posedge clk); #1;       // accepted; BUSY cycle 1
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;       // BUSY cycle 2
    @(posedge clk); #1;       // BUSY cycle 3
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0 || res_v[0] !== '0) begin
      n_fail++;
      $display("FAIL abort_async: in_ready=%b out_valid=%b res=%h, required 0/0/0",
               in_ready_v[0], out_valid_v[0], res_v[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b, required 1", in_ready_v[0]);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      // A stray out_ready with no result pending must be ignored.
      out_ready_v[0] = (i == 5);
      @(posedge clk); #1;
      if (out_valid_v[0] !== 1'b0) seen++;
    end
    out_ready_v[0] = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid seen %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_sweep();
    res_t         obs, exp;
    int           lat;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    for (int s = 0; s < NI; s++) begin
      for (int k = 0; k < 10; k++) begin
        a  = W'($urandom);
        b  = (k % 4 == 3) ? a : W'($urandom);
        op = 3'($urandom_range(0, 7));
        run_txn(s, a, b, op, obs, lat);
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL sweep_result u%0d op%0d a=%h b=%h: got %h, required %h", s, op, a, b, obs, exp);
        end
        n_checks++;
        if (lat != lat_for(s)) begin
          n_fail++;
          $display("FAIL sweep_latency u%0d: got %0d, required %0d", s, lat, lat_for(s));
        end
        release_out(s);
        n_checks++;
        if (in_ready_v[s] !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep_release u%0d: in_ready=%b, required 1", s, in_ready_v[s]);
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NI; s++) begin
      in_valid_v[s]  = 1'b0;
      a_v[s]         = '0;
      b_v[s]         = '0;
      op_v[s]        = '0;
      out_ready_v[s] = 1'b0;
    end
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rev_alu_serial.md
# rev_alu_serial

Digit-serial, parametrised N-bit ALU datapath whose bit-slice is composed of the team's reversible gate cells: Feynman for XOR/copy, Toffoli for AND, Peres/DPG for full-add, Fredkin for operand steering. It is the multi-bit successor to the 1-bit reversible ALU slice. It accepts one operand pair per transaction over a valid/ready handshake and processes DIGIT bits per clock, LSB digit first. It returns the result with carry, zero and overflow flags over a second valid/ready handshake.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of DIGIT, ≥ 2.
- DIGIT, 4: bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair and op presented.
- in_ready  out  1  block can accept a transaction.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select (see Operation).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- cout  out  1  carry out (ADD/SUB only, else 0).
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- zero  out  1  y == 0.

## Operation
- Op codes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1, with cout = no-borrow.
  - 010 AND.
  - 011 OR: (A^B)^(A&B).
  - 100 XOR.
  - 101 XNOR.
  - 110 PASS A.
  - 111 NOT A.
- FSM states IDLE, BUSY, DONE; reset state IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready, latch a, b and op. Clear the digit counter. Load the carry register with 1 for SUB, else 0. Go to BUSY.
- BUSY: each cycle, the slice chain computes the current DIGIT bits from the latched operand digits and the carry register. It writes them into y at digit position cnt, updates the carry register, and increments cnt. After digit WIDTH/DIGIT−1 is written, go to DONE.
- DONE: out_valid = 1, and y/cout/ovf/zero are held stable. On out_ready, go to IDLE.
- Flag rules:
  - cout = final carry register.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero is computed on the full WIDTH result.
  - cout and ovf are forced to 0 for ops 010–111.
- Operand registers are not modified during BUSY. Inputs a, b and op may change freely after acceptance.
- Reset asserted mid-transaction aborts it; no partial result is ever presented.
- An illegal WIDTH/DIGIT combination is a elaboration-time error (generate-time check).

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 0 while rst high, 1 on the first cycle after release.
  - out_valid = 0.
  - y = 0, cout = 0, ovf = 0, zero = 0.
  - Internal carry and counter = 0.
- Acceptance edge = cycle 0. BUSY occupies cycles 1..WIDTH/DIGIT. out_valid rises on the edge ending the last BUSY cycle.
- Latency from acceptance to out_valid is WIDTH/DIGIT+1 clocks (5 for 16/4).
- in_ready is low throughout BUSY and DONE, so there is exactly one transaction in flight.
- out_valid & out_ready on cycle k: in_ready is high on cycle k+1. There is no same-cycle turnaround, so peak throughput is one result per WIDTH/DIGIT+2 clocks.
- Back-pressure: out_valid held indefinitely while out_ready is low; outputs do not change.
- out_ready asserted while out_valid is low is ignored.
- in_valid held high across a whole transaction: the next pair is accepted only on the first IDLE cycle.
- y, cout, ovf and zero are registered. They are updated only on the BUSY→DONE transition and retain their value through IDLE until the next result.

## Test plan
- Reset, then ADD with WIDTH=16, DIGIT=4, a=0x7FFF, b=0x0001 → out_valid exactly 5 clocks after acceptance, y=0x8000, cout=0, ovf=1, zero=0.
- SUB a=0x1234, b=0x1234 → y=0x0000, cout=1, ovf=0, zero=1. Then SUB a=0x0000, b=0x0001 → y=0xFFFF, cout=0, ovf=0.
- Logic sweep with a=0xF0F0, b=0xFF00, ops 010..111 → results in order:
  - AND 0xF000
  - OR 0xFFF0
  - XOR 0x0FF0
  - XNOR 0xF00F
  - PASS 0xF0F0
  - NOT 0x0F0F
  - cout=ovf=0 for all.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → y stable, in_ready=0 throughout. Pulse out_ready → in_ready=1 the next cycle. An in_valid held high throughout is accepted on that cycle.
- Assert rst during the third BUSY cycle of ADD 0xFFFF+0x0001 → all outputs return to reset values asynchronously. After release, no out_valid appears without a new transaction.
- Parameter sweep with DIGIT=1 and DIGIT=16 (WIDTH=16), running random ADD/SUB/logic vectors → matches the reference model, with latency 17 and 2 clocks respectively.
